// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, op codes,
// FSM state encoding, data-bus command payload and lane/byte-enable helpers.
// The optional MEM_ALIGN_EXC_EN build macro is consumed by mem_access.sv.
package mem_access_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned OpW      = 4;
  localparam int unsigned BeW      = 4;

  localparam logic [DataW-1:0]    ZeroWord  = DataW'(0);
  localparam logic [RegAddrW-1:0] RegAddr_0 = RegAddrW'(0);

  // Memory op codes; 9-15 are unused and behave as OP_NONE.
  localparam logic [OpW-1:0] OP_NONE = 4'd0;
  localparam logic [OpW-1:0] OP_LB   = 4'd1;
  localparam logic [OpW-1:0] OP_LBU  = 4'd2;
  localparam logic [OpW-1:0] OP_LH   = 4'd3;
  localparam logic [OpW-1:0] OP_LHU  = 4'd4;
  localparam logic [OpW-1:0] OP_LW   = 4'd5;
  localparam logic [OpW-1:0] OP_SB   = 4'd6;
  localparam logic [OpW-1:0] OP_SH   = 4'd7;
  localparam logic [OpW-1:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Data-bus command held stable for the whole transaction.
  typedef struct packed {
    logic             wr;
    logic [DataW-1:0] addr;
    logic [BeW-1:0]   be;
    logic [DataW-1:0] wdata;
  } dbus_cmd_t;

  function automatic logic is_mem(input logic [OpW-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [OpW-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_load(input logic [OpW-1:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_half(input logic [OpW-1:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [OpW-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Big-endian lanes: offset 0 is the most significant byte.
  function automatic logic [BeW-1:0] be_for(input logic [OpW-1:0] op,
                                            input logic [1:0]     off);
    if (is_word(op))      return 4'b1111;
    else if (is_half(op)) return off[1] ? 4'b0011 : 4'b1100;
    else                  return 4'(4'b1000 >> off);
  endfunction

  function automatic logic [DataW-1:0] wdata_for(input logic [OpW-1:0]   op,
                                                 input logic [DataW-1:0] sd);
    case (op)
      OP_SB:   return {4{sd[7:0]}};
      OP_SH:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Load-data lane selection and extension (combinational).
// Ports: op (load op code), offset (byte offset within word),
//        rdata (raw bus word), data (aligned, extended result).
module mem_align
  import mem_access_pkg::*;
(
  input  logic [OpW-1:0]   op,
  input  logic [1:0]       offset,
  input  logic [DataW-1:0] rdata,
  output logic [DataW-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane pick: offset 0 is rdata[31:24].
  always_comb begin
    byte_lane = rdata[31:24];
    case (offset)
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      2'd3:    byte_lane = rdata[7:0];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  // Extension by op.
  always_comb begin
    data = ZeroWord;
    case (op)
      OP_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  data = {24'd0, byte_lane};
      OP_LH:   data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  data = {16'd0, half_lane};
      OP_LW:   data = rdata;
      default: data = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-bus transactions for loads and
// stores, stalls earlier stages while the bus is busy and registers the
// writeback triple for mem_wb.
// Ports: clk, rst (async active-low); ex_mem inputs mem_result, mem_we,
//        mem_waddr, mem_op, store_data; dbus_* request/response; wb_*
//        writeback; stall_req (combinational); exc_adel/exc_ades/bad_vaddr.
// Build option: define MEM_ALIGN_EXC_EN to raise address-error exceptions on
// misaligned half/word accesses instead of masking the low address bits.
module mem_access
  import mem_access_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DataW-1:0]    mem_result,
  input  logic                mem_we,
  input  logic [RegAddrW-1:0] mem_waddr,
  input  logic [OpW-1:0]      mem_op,
  input  logic [DataW-1:0]    store_data,
  output logic                dbus_req,
  output logic                dbus_wr,
  output logic [DataW-1:0]    dbus_addr,
  output logic [BeW-1:0]      dbus_be,
  output logic [DataW-1:0]    dbus_wdata,
  input  logic                dbus_ack,
  input  logic [DataW-1:0]    dbus_rdata,
  output logic [DataW-1:0]    wb_result,
  output logic                wb_we,
  output logic [RegAddrW-1:0] wb_waddr,
  output logic                stall_req,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [DataW-1:0]    bad_vaddr
);

  state_e               state, state_nxt;
  dbus_cmd_t            cmd_q, cmd_nxt;
  logic                 req_q, req_nxt;
  logic [OpW-1:0]       op_q, op_nxt;
  logic [1:0]           off_q, off_nxt;
  logic [DataW-1:0]     wb_result_nxt;
  logic                 wb_we_nxt;
  logic [RegAddrW-1:0]  wb_waddr_nxt;
  logic                 exc_adel_nxt, exc_ades_nxt;
  logic [DataW-1:0]     bad_vaddr_nxt;
  logic                 mem_valid, mem_go;
  logic [1:0]           eff_off;
  logic [DataW-1:0]     load_data;

  assign mem_valid = is_mem(mem_op);

`ifdef MEM_ALIGN_EXC_EN
  logic misaligned;
  assign misaligned = (is_half(mem_op) && mem_result[0]) ||
                      (is_word(mem_op) && (mem_result[1:0] != 2'b00));
  // A misaligned access traps in IDLE and never starts a transaction.
  assign mem_go = mem_valid && !misaligned;
`else
  assign mem_go = mem_valid;
`endif

  // Offset masked to the access size.
  assign eff_off = is_word(mem_op) ? 2'b00 :
                   is_half(mem_op) ? {mem_result[1], 1'b0} : mem_result[1:0];

  assign stall_req = ((state == S_IDLE) && mem_go) || (state == S_BUSY);

  mem_align u_align (
    .op     (op_q),
    .offset (off_q),
    .rdata  (dbus_rdata),
    .data   (load_data)
  );

  // Next-state and next register values.
  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd_q;
    req_nxt       = req_q;
    op_nxt        = op_q;
    off_nxt       = off_q;
    wb_result_nxt = wb_result;
    wb_we_nxt     = wb_we;
    wb_waddr_nxt  = wb_waddr;
    exc_adel_nxt  = 1'b0;
    exc_ades_nxt  = 1'b0;
    bad_vaddr_nxt = bad_vaddr;
    case (state)
      S_IDLE: begin
        if (mem_go) begin
          state_nxt = S_BUSY;
          req_nxt   = 1'b1;
          cmd_nxt   = '{wr:    is_store(mem_op),
                        addr:  {mem_result[31:2], 2'b00},
                        be:    be_for(mem_op, eff_off),
                        wdata: wdata_for(mem_op, store_data)};
          op_nxt    = mem_op;
          off_nxt   = eff_off;
          wb_we_nxt = 1'b0;
        end
`ifdef MEM_ALIGN_EXC_EN
        else if (mem_valid) begin
          exc_adel_nxt  = is_load(mem_op);
          exc_ades_nxt  = is_store(mem_op);
          bad_vaddr_nxt = mem_result;
          wb_we_nxt     = 1'b0;
        end
`endif
        else begin
          wb_result_nxt = mem_result;
          wb_we_nxt     = mem_we;
          wb_waddr_nxt  = mem_waddr;
        end
      end
      S_BUSY: begin
        if (dbus_ack) begin
          state_nxt     = S_DONE;
          req_nxt       = 1'b0;
          wb_result_nxt = cmd_q.wr ? ZeroWord : load_data;
          wb_we_nxt     = mem_we;
          wb_waddr_nxt  = mem_waddr;
        end else begin
          wb_we_nxt = 1'b0;
        end
      end
      S_DONE: begin
        // Same instruction is still presented; drop it.
        state_nxt = S_IDLE;
        wb_we_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
        wb_we_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      req_q     <= 1'b0;
      op_q      <= OP_NONE;
      off_q     <= 2'b00;
      wb_result <= ZeroWord;
      wb_we     <= 1'b0;
      wb_waddr  <= RegAddr_0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      bad_vaddr <= ZeroWord;
    end else begin
      state     <= state_nxt;
      cmd_q     <= cmd_nxt;
      req_q     <= req_nxt;
      op_q      <= op_nxt;
      off_q     <= off_nxt;
      wb_result <= wb_result_nxt;
      wb_we     <= wb_we_nxt;
      wb_waddr  <= wb_waddr_nxt;
      exc_adel  <= exc_adel_nxt;
      exc_ades  <= exc_ades_nxt;
      bad_vaddr <= bad_vaddr_nxt;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_wr    = cmd_q.wr;
  assign dbus_addr  = cmd_q.addr;
  assign dbus_be    = cmd_q.be;
  assign dbus_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_result;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [3:0]  mem_op;
  logic [31:0] store_data;
  logic        dbus_req, dbus_wr;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [31:0] wb_result;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic        stall_req;
  logic        exc_adel, exc_ades;
  logic [31:0] bad_vaddr;

  int n_checks = 0;
  int n_fails  = 0;

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .mem_result (mem_result),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_op     (mem_op),
    .store_data (store_data),
    .dbus_req   (dbus_req),
    .dbus_wr    (dbus_wr),
    .dbus_addr  (dbus_addr),
    .dbus_be    (dbus_be),
    .dbus_wdata (dbus_wdata),
    .dbus_ack   (dbus_ack),
    .dbus_rdata (dbus_rdata),
    .wb_result  (wb_result),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .stall_req  (stall_req),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bad_vaddr  (bad_vaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [31:0] res, input logic we,
                        input logic [4:0] wa, input logic [31:0] sd);
    mem_op = op; mem_result = res; mem_we = we; mem_waddr = wa; store_data = sd;
  endtask

  // Load with ack in the first BUSY cycle.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_res);
    set_in(op, addr, 1'b1, 5'd9, 32'h0);
    #1 check({tag, ".stall_idle"}, 32'(stall_req), 32'd1);
    step();
    check({tag, ".req"}, 32'(dbus_req), 32'd1);
    check({tag, ".wr"}, 32'(dbus_wr), 32'd0);
    check({tag, ".addr"}, dbus_addr, exp_addr);
    check({tag, ".be"}, 32'(dbus_be), 32'(exp_be));
    check({tag, ".stall_busy"}, 32'(stall_req), 32'd1);
    check({tag, ".bubble"}, 32'(wb_we), 32'd0);
    dbus_ack = 1'b1; dbus_rdata = rdata;
    step();
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    check({tag, ".result"}, wb_result, exp_res);
    check({tag, ".we"}, 32'(wb_we), 32'd1);
    check({tag, ".waddr"}, 32'(wb_waddr), 32'd9);
    check({tag, ".req_done"}, 32'(dbus_req), 32'd0);
    check({tag, ".stall_done"}, 32'(stall_req), 32'd0);
    step();
    check({tag, ".we_after_done"}, 32'(wb_we), 32'd0);
    set_in(4'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
  endtask

  initial begin
    rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    set_in(4'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step(); step();
    check("rst.req", 32'(dbus_req), 32'd0);
    check("rst.wb_result", wb_result, 32'h0);
    check("rst.wb_we", 32'(wb_we), 32'd0);
    check("rst.stall", 32'(stall_req), 32'd0);
    rst = 1'b1;

    // ALU pass-through
    set_in(4'd0, 32'h12345678, 1'b1, 5'd3, 32'h0);
    #1 check("alu.stall", 32'(stall_req), 32'd0);
    step();
    check("alu.result", wb_result, 32'h12345678);
    check("alu.we", 32'(wb_we), 32'd1);
    check("alu.waddr", 32'(wb_waddr), 32'd3);

    // Unused op code behaves as NONE; ack while IDLE is ignored
    set_in(4'd12, 32'h00000055, 1'b1, 5'd4, 32'h0);
    dbus_ack = 1'b1;
    #1 check("op12.stall", 32'(stall_req), 32'd0);
    step();
    dbus_ack = 1'b0;
    check("op12.result", wb_result, 32'h00000055);
    check("op12.waddr", 32'(wb_waddr), 32'd4);
    check("op12.req", 32'(dbus_req), 32'd0);

    // Loads
    do_load("lb", 4'd1, 32'h00000101, 32'h11AA2233, 32'h00000100, 4'b0100, 32'hFFFFFFAA);
    do_load("lhu", 4'd4, 32'h00000512, 32'h1234ABCD, 32'h00000510, 4'b0011, 32'h0000ABCD);
    do_load("lh", 4'd3, 32'h00000600, 32'h8001FFFF, 32'h00000600, 4'b1100, 32'hFFFF8001);
    do_load("lbu", 4'd2, 32'h00000703, 32'h000000F0, 32'h00000700, 4'b0001, 32'h000000F0);

    // SH with three wait cycles
    set_in(4'd7, 32'h00000202, 1'b0, 5'd6, 32'hDEADBEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      check("sh.req_wait", 32'(dbus_req), 32'd1);
      check("sh.wdata_wait", dbus_wdata, 32'hBEEFBEEF);
      check("sh.wb_we_wait", 32'(wb_we), 32'd0);
      step();
    end
    check("sh.req", 32'(dbus_req), 32'd1);
    check("sh.wr", 32'(dbus_wr), 32'd1);
    check("sh.be", 32'(dbus_be), 32'h3);
    check("sh.wdata", dbus_wdata, 32'hBEEFBEEF);
    check("sh.addr", dbus_addr, 32'h00000200);
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    check("sh.wb_we", 32'(wb_we), 32'd0);
    check("sh.wb_result", wb_result, 32'h0);
    check("sh.req_done", 32'(dbus_req), 32'd0);
    step();
    set_in(4'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    // SB at offset 3
    set_in(4'd6, 32'h00000803, 1'b0, 5'd0, 32'h0000007E);
    step();
    check("sb.be", 32'(dbus_be), 32'h1);
    check("sb.wdata", dbus_wdata, 32'h7E7E7E7E);
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    step();
    set_in(4'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    // Misaligned LW
`ifdef MEM_ALIGN_EXC_EN
    set_in(4'd5, 32'h00000302, 1'b1, 5'd8, 32'h0);
    #1 check("lw_mis.stall", 32'(stall_req), 32'd0);
    step();
    check("lw_mis.req", 32'(dbus_req), 32'd0);
    check("lw_mis.adel", 32'(exc_adel), 32'd1);
    check("lw_mis.ades", 32'(exc_ades), 32'd0);
    check("lw_mis.bad_vaddr", bad_vaddr, 32'h00000302);
    check("lw_mis.wb_we", 32'(wb_we), 32'd0);
    set_in(4'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check("lw_mis.adel_pulse", 32'(exc_adel), 32'd0);
`else
    do_load("lw_mis", 4'd5, 32'h00000302, 32'hCAFEF00D, 32'h00000300, 4'b1111, 32'hCAFEF00D);
    check("lw_mis.adel", 32'(exc_adel), 32'd0);
    check("lw_mis.bad_vaddr", bad_vaddr, 32'h0);
`endif

    // Reset mid-transaction
    set_in(4'd5, 32'h00000400, 1'b1, 5'd10, 32'h0);
    step();
    check("rstb.req_busy", 32'(dbus_req), 32'd1);
    #2 rst = 1'b0;
    #1 check("rstb.req_drop", 32'(dbus_req), 32'd0);
    check("rstb.wb_we", 32'(wb_we), 32'd0);
    set_in(4'd0, 32'hA5A5A5A5, 1'b1, 5'd7, 32'h0);
    step();
    rst = 1'b1;
    dbus_ack = 1'b1; dbus_rdata = 32'h11111111;
    #1 check("rstb.stall", 32'(stall_req), 32'd0);
    step();
    dbus_ack = 1'b0;
    check("rstb.alu_result", wb_result, 32'hA5A5A5A5);
    check("rstb.alu_we", 32'(wb_we), 32'd1);
    check("rstb.alu_waddr", 32'(wb_waddr), 32'd7);
    check("rstb.req", 32'(dbus_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
